// File: rtl/lsu_bus_master.sv
// Data-side bus initiator: one load/store at a time onto DAD/DDT/MREQ/WRITE/SIZE, ack-terminated with watchdog.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word requests are trapped locally and never issued on the bus.
module lsu_bus_master #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        resp_misalign,
    output logic [31:0] DAD,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    inout  wire  [31:0] DDT,
    input  logic        ACKD_n
);

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] wdata_q;
    logic        uns_q;
    logic [15:0] wd_count;
    logic [1:0]  bus_size;
    logic        misaligned;
    logic [31:0] load_data;

    assign req_ready = (state == IDLE);
    assign DDT       = (MREQ && WRITE) ? wdata_q : 'z;

    always_comb begin
        bus_size = 2'b00;
        case (req_size)
            2'b00:   bus_size = 2'b10;
            2'b01:   bus_size = 2'b01;
            default: bus_size = 2'b00;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            default: misaligned = |req_addr[1:0];
        endcase
`endif
    end

    // Formatting keys off the latched bus size code, not the original req_size.
    always_comb begin
        load_data = DDT;
        case (SIZE)
            2'b10:   load_data = {{24{~uns_q & DDT[7]}}, DDT[7:0]};
            2'b01:   load_data = {{16{~uns_q & DDT[15]}}, DDT[15:0]};
            default: load_data = DDT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            MREQ          <= 1'b0;
            WRITE         <= 1'b0;
            SIZE          <= 2'b00;
            DAD           <= '0;
            wdata_q       <= '0;
            uns_q         <= 1'b0;
            wd_count      <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            resp_misalign <= 1'b0;
        end else begin
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            resp_misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (misaligned) begin
                            resp_valid    <= 1'b1;
                            resp_misalign <= 1'b1;
                        end else begin
                            DAD      <= req_addr;
                            WRITE    <= req_we;
                            SIZE     <= bus_size;
                            wdata_q  <= req_wdata;
                            uns_q    <= req_unsigned;
                            wd_count <= '0;
                            MREQ     <= 1'b1;
                            state    <= BUS;
                        end
                    end
                end
                BUS: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (!ACKD_n) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= WRITE ? '0 : load_data;
                        MREQ       <= 1'b0;
                        WRITE      <= 1'b0;
                        state      <= IDLE;
                    end else if (wd_count == WD_LAST) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        MREQ       <= 1'b0;
                        WRITE      <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        wd_count <= wd_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed cases plus randomized accesses against an arithmetic reference.
module tb_lsu_bus_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        resp_misalign;
    logic [31:0] DAD;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    wire  [31:0] DDT;
    logic        ACKD_n;

    logic        rsp_drive;
    logic [31:0] rsp_data;
    assign DDT = rsp_drive ? rsp_data : 'z;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_bus_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_misalign(resp_misalign), .DAD(DAD),
        .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .DDT(DDT), .ACKD_n(ACKD_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_size(input logic [1:0] sz);
        if (sz == 2'd0) return 2'b10;
        if (sz == 2'd1) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns, input logic [31:0] b);
        longint v;
        if (sz == 2'd0) begin
            v = b % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = b % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = b;
        end
        return v[31:0];
    endfunction

    function automatic bit is_misaligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz >= 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    // waitc = number of MREQ cycles until ack (0 = responder never acks)
    task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] bus_val, input int waitc);
        int n;
        bit trap;
        @(negedge clk);
        check("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = is_misaligned(sz, addr);
`endif
        if (trap) begin
            check("trap_mreq", MREQ, 1'b0);
            check("trap_valid", resp_valid, 1'b1);
            check("trap_misalign", resp_misalign, 1'b1);
            check("trap_err", resp_err, 1'b0);
            check("trap_rdata", resp_rdata, 32'h0);
            @(negedge clk);
            check("trap_valid_once", resp_valid, 1'b0);
            check("trap_mreq_after", MREQ, 1'b0);
            return;
        end
        n = (waitc == 0) ? TO : waitc;
        for (int k = 1; k <= n; k++) begin
            check("bus_mreq", MREQ, 1'b1);
            check("bus_write", WRITE, we);
            check("bus_size", SIZE, exp_size(sz));
            check("bus_dad", DAD, addr);
            check("bus_ready_low", req_ready, 1'b0);
            check("bus_no_resp", resp_valid, 1'b0);
            if (we) check("bus_ddt", DDT, wdata);
            if (k == n && waitc != 0) begin
                ACKD_n = 1'b0;
                if (!we) begin
                    rsp_drive = 1'b1;
                    rsp_data  = bus_val;
                end
            end
            @(negedge clk);
        end
        ACKD_n = 1'b1;
        rsp_drive = 1'b0;
        check("done_mreq", MREQ, 1'b0);
        check("done_write", WRITE, 1'b0);
        check("done_valid", resp_valid, 1'b1);
        check("done_ready", req_ready, 1'b1);
        check("done_err", resp_err, (waitc == 0));
        check("done_misalign", resp_misalign, 1'b0);
        check("done_rdata", resp_rdata, (waitc == 0 || we) ? 32'h0 : exp_load(sz, uns, bus_val));
        @(negedge clk);
        check("valid_one_cycle", resp_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        ACKD_n = 1'b1; rsp_drive = 1'b0; rsp_data = '0;

        @(negedge clk);
        check("rst_mreq", MREQ, 1'b0);
        check("rst_write", WRITE, 1'b0);
        check("rst_size", SIZE, 2'b00);
        check("rst_dad", DAD, 32'h0);
        check("rst_valid", resp_valid, 1'b0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", resp_err, 1'b0);
        check("rst_misalign", resp_misalign, 1'b0);
        check("rst_ready", req_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        access(1'b0, 2'd2, 1'b0, 32'h0800_0010, 32'h0, 32'hDEAD_BEEF, 1);
        access(1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0, 32'h1234_5680, 1);
        access(1'b0, 2'd0, 1'b1, 32'h0000_0102, 32'h0, 32'h1234_5680, 2);
        access(1'b0, 2'd1, 1'b0, 32'h0000_0200, 32'h0, 32'hABCD_8001, 1);
        access(1'b0, 2'd1, 1'b1, 32'h0000_0202, 32'h0, 32'hABCD_8001, 1);
        access(1'b0, 2'd3, 1'b1, 32'h0000_0300, 32'h0, 32'h8765_4321, 1);
        access(1'b1, 2'd0, 1'b0, 32'hF000_0000, 32'hAABB_CC41, 32'h0, 3);
        access(1'b0, 2'd2, 1'b0, 32'h0800_0020, 32'h0, 32'h0, 0);
        access(1'b0, 2'd2, 1'b0, 32'h0800_0024, 32'h0, 32'h5555_AAAA, TO);
        access(1'b0, 2'd2, 1'b0, 32'h0800_0002, 32'h0, 32'hCAFE_F00D, 1);

        // ACKD_n while idle must not produce a response
        @(negedge clk);
        ACKD_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_ack_valid", resp_valid, 1'b0);
            check("idle_ack_mreq", MREQ, 1'b0);
        end
        ACKD_n = 1'b1;

        // Reset in the middle of a store's bus phase
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0000_4000; req_wdata = 32'h1357_9BDF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_mreq", MREQ, 1'b1);
        check("pre_rst_ddt", DDT, 32'h1357_9BDF);
        #2 rst = 1'b1;
        #1;
        check("async_rst_mreq", MREQ, 1'b0);
        check("async_rst_write", WRITE, 1'b0);
        check("async_rst_dad", DAD, 32'h0);
        check("async_rst_size", SIZE, 2'b00);
        check("async_rst_ready", req_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("post_rst_no_resp", resp_valid, 1'b0);
            check("post_rst_mreq", MREQ, 1'b0);
        end
        access(1'b0, 2'd1, 1'b0, 32'h0000_4002, 32'h0, 32'h0000_7FFF, 2);

        for (int t = 0; t < 40; t++) begin
            logic        we;
            logic [1:0]  sz;
            logic        uns;
            logic [31:0] addr;
            logic [31:0] wd;
            logic [31:0] bv;
            int          w;
            we   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            addr = $urandom;
            wd   = $urandom;
            bv   = $urandom;
            w    = $urandom_range(0, 5);
            access(we, sz, uns, addr, wd, bv, w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
